// File: rtl/noc_input_stage_pkg.sv
// Shared router input-stage definitions: direction codes, judge fail-bit layout, header field offsets.
// Constants only; no latency or backpressure of its own.
package noc_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_NONE  = 2'b00;
  localparam dir_t DIR_X     = 2'b01;
  localparam dir_t DIR_Y     = 2'b10;
  localparam dir_t DIR_LOCAL = 2'b11;

  localparam int FAIL_X = 2;
  localparam int FAIL_Y = 1;
  localparam int FAIL_L = 0;

  // Header fields sit at the top of the packet, counted in coordinate-width slots from the MSB.
  localparam int HDR_X_SLOT = 0;
  localparam int HDR_Y_SLOT = 1;

  function automatic int hdr_msb(input int dw, input int cw, input int slot);
    return dw - 1 - slot * cw;
  endfunction

endpackage

// File: rtl/noc_input_stage_if.sv
// Input-stage bundle: three valid/ready packet ports, head direction/packet/HOL outputs, judge fail vector.
// Master is the upstream/judge side, slave is the input stage.
interface noc_input_stage_if #(
  parameter int DW   = 16,
  parameter int HOLW = 8
);
  logic            in_x_valid;
  logic [DW-1:0]   in_x_data;
  logic            in_x_ready;
  logic            in_y_valid;
  logic [DW-1:0]   in_y_data;
  logic            in_y_ready;
  logic            in_l_valid;
  logic [DW-1:0]   in_l_data;
  logic            in_l_ready;
  logic [1:0]      dout_x;
  logic [1:0]      dout_y;
  logic [1:0]      dout_local;
  logic [DW-1:0]   pkt_x;
  logic [DW-1:0]   pkt_y;
  logic [DW-1:0]   pkt_local;
  logic [2:0]      fail;
  logic [HOLW-1:0] hol_x;
  logic [HOLW-1:0] hol_y;
  logic [HOLW-1:0] hol_local;

  modport master (
    output in_x_valid, in_x_data, in_y_valid, in_y_data, in_l_valid, in_l_data, fail,
    input  in_x_ready, in_y_ready, in_l_ready, dout_x, dout_y, dout_local,
    input  pkt_x, pkt_y, pkt_local, hol_x, hol_y, hol_local
  );

  modport slave (
    input  in_x_valid, in_x_data, in_y_valid, in_y_data, in_l_valid, in_l_data, fail,
    output in_x_ready, in_y_ready, in_l_ready, dout_x, dout_y, dout_local,
    output pkt_x, pkt_y, pkt_local, hol_x, hol_y, hol_local
  );
endinterface

// File: rtl/noc_input_stage_port.sv
// One input port: FIFO, XY route of the head, head-of-line retry counter. Head visible one cycle after push.
// Backpressure: ready drops when the FIFO holds DEPTH entries, regardless of a same-cycle pop.
module noc_in_port
  import noc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int HOLW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  input  logic            fail,
  output dir_t            dout,
  output logic [DW-1:0]   pkt,
  output logic [HOLW-1:0] hol
);

  localparam int AW    = $clog2(DEPTH);
  localparam int X_MSB = hdr_msb(DW, CW, HDR_X_SLOT);
  localparam int Y_MSB = hdr_msb(DW, CW, HDR_Y_SLOT);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   MY_XC    = CW'(MY_X);
  localparam logic [CW-1:0]   MY_YC    = CW'(MY_Y);
  localparam logic [HOLW-1:0] HOL_MAX  = {HOLW{1'b1}};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;
  logic          empty;

  assign empty    = (count == '0);
  assign in_ready = (count != CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (dout != DIR_NONE) && !fail;
  assign head     = mem[rd_ptr];

  always_comb begin
    dout = DIR_NONE;
    pkt  = '0;
    if (!empty) begin
      pkt = head;
      if (head[X_MSB -: CW] != MY_XC)
        dout = DIR_X;
      else if (head[Y_MSB -: CW] != MY_YC)
        dout = DIR_Y;
      else
        dout = DIR_LOCAL;
    end
  end

  // Storage carries no reset; an empty FIFO masks its contents from dout/pkt.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hol <= '0;
    else if (empty || pop)
      hol <= '0;
    else if (fail && hol != HOL_MAX)
      hol <= hol + HOLW'(1);
  end

endmodule

// File: rtl/noc_input_stage.sv
// Router input stage: X, Y and LOCAL ports buffered and XY-routed for the conflict judge; 1-cycle push-to-head.
// Backpressure per port via in_*_ready; judge fail bits hold the matching head for retry.
module noc_input_stage
  import noc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int HOLW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  noc_input_stage_if.slave   bus
);

  noc_in_port #(
    .DW(DW), .DEPTH(DEPTH), .CW(CW), .MY_X(MY_X), .MY_Y(MY_Y), .HOLW(HOLW)
  ) u_port_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_x_valid),
    .in_data  (bus.in_x_data),
    .in_ready (bus.in_x_ready),
    .fail     (bus.fail[FAIL_X]),
    .dout     (bus.dout_x),
    .pkt      (bus.pkt_x),
    .hol      (bus.hol_x)
  );

  noc_in_port #(
    .DW(DW), .DEPTH(DEPTH), .CW(CW), .MY_X(MY_X), .MY_Y(MY_Y), .HOLW(HOLW)
  ) u_port_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_y_valid),
    .in_data  (bus.in_y_data),
    .in_ready (bus.in_y_ready),
    .fail     (bus.fail[FAIL_Y]),
    .dout     (bus.dout_y),
    .pkt      (bus.pkt_y),
    .hol      (bus.hol_y)
  );

  noc_in_port #(
    .DW(DW), .DEPTH(DEPTH), .CW(CW), .MY_X(MY_X), .MY_Y(MY_Y), .HOLW(HOLW)
  ) u_port_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_l_valid),
    .in_data  (bus.in_l_data),
    .in_ready (bus.in_l_ready),
    .fail     (bus.fail[FAIL_L]),
    .dout     (bus.dout_local),
    .pkt      (bus.pkt_local),
    .hol      (bus.hol_local)
  );

endmodule

// File: tb/tb_noc_input_stage.sv
// Directed bench: dut_a at node (1,1) with 8-bit HOL counters, dut_b at node (0,0) with 2-bit HOL counters.
module tb_noc_input_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  noc_input_stage_if #(.DW(16), .HOLW(8)) ia ();
  noc_input_stage_if #(.DW(16), .HOLW(2)) ib ();

  noc_input_stage #(.DW(16), .DEPTH(4), .CW(2), .MY_X(1), .MY_Y(1), .HOLW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  noc_input_stage #(.DW(16), .DEPTH(4), .CW(2), .MY_X(0), .MY_Y(0), .HOLW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  function automatic logic [15:0] hdr(input int x, input int y, input int p);
    hdr = {x[1:0], y[1:0], p[11:0]};
  endfunction

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ia.in_x_valid = 0; ia.in_y_valid = 0; ia.in_l_valid = 0;
    ia.in_x_data = '0; ia.in_y_data = '0; ia.in_l_data = '0; ia.fail = 3'b000;
    ib.in_x_valid = 0; ib.in_y_valid = 0; ib.in_l_valid = 0;
    ib.in_x_data = '0; ib.in_y_data = '0; ib.in_l_data = '0; ib.fail = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({ib.in_x_ready, ib.in_y_ready, ib.in_l_ready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 111", {ib.in_x_ready, ib.in_y_ready, ib.in_l_ready});
    end
    n_tests++;
    if ({ib.dout_x, ib.dout_y, ib.dout_local} !== 6'b0) begin
      n_fail++; $display("FAIL reset_dout: got %b expected 000000", {ib.dout_x, ib.dout_y, ib.dout_local});
    end
    n_tests++;
    if ({ib.hol_x, ib.hol_y, ib.hol_local, ib.pkt_x} !== 22'h0) begin
      n_fail++; $display("FAIL reset_hol_pkt: got %h expected 0", {ib.hol_x, ib.hol_y, ib.hol_local, ib.pkt_x});
    end
    // Burst on X at node (0,0); header (1,0) routes X; keep it held so hol counts.
    ib.fail = 3'b100;
    ib.in_x_valid = 1; ib.in_x_data = hdr(1, 0, 1);
    tick();
    ib.in_x_data = hdr(1, 0, 2);
    tick();
    tick();
    n_tests++;
    if (ib.dout_x !== 2'b01 || ib.hol_x == 2'd0) begin
      n_fail++; $display("FAIL burst_before_reset: dout_x=%b hol_x=%0d expected 01 and nonzero", ib.dout_x, ib.hol_x);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ib.in_x_ready, ib.dout_x, ib.hol_x} !== {1'b1, 2'b00, 2'd0}) begin
      n_fail++; $display("FAIL async_reset: ready/dout/hol got %b expected 1_00_00", {ib.in_x_ready, ib.dout_x, ib.hol_x});
    end
    idle_inputs();
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_routing();
    ia.fail = 3'b111;
    ia.in_x_valid = 1; ia.in_x_data = hdr(2, 1, 'h111);
    ia.in_y_valid = 1; ia.in_y_data = hdr(1, 3, 'h222);
    ia.in_l_valid = 1; ia.in_l_data = hdr(1, 1, 'h333);
    tick();
    ia.in_x_valid = 0; ia.in_y_valid = 0; ia.in_l_valid = 0;
    n_tests++;
    if (ia.dout_x !== 2'b01) begin n_fail++; $display("FAIL route_x: got %b expected 01", ia.dout_x); end
    n_tests++;
    if (ia.dout_y !== 2'b10) begin n_fail++; $display("FAIL route_y: got %b expected 10", ia.dout_y); end
    n_tests++;
    if (ia.dout_local !== 2'b11) begin n_fail++; $display("FAIL route_local: got %b expected 11", ia.dout_local); end
    n_tests++;
    if ({ia.pkt_x, ia.pkt_y, ia.pkt_local} !== {hdr(2, 1, 'h111), hdr(1, 3, 'h222), hdr(1, 1, 'h333)}) begin
      n_fail++; $display("FAIL route_pkt: got %h %h %h expected %h %h %h", ia.pkt_x, ia.pkt_y, ia.pkt_local,
                         hdr(2, 1, 'h111), hdr(1, 3, 'h222), hdr(1, 1, 'h333));
    end
    ia.fail = 3'b000;
    tick();
    n_tests++;
    if ({ia.dout_x, ia.dout_y, ia.dout_local} !== 6'b0) begin
      n_fail++; $display("FAIL route_pop_all: got %b expected 000000", {ia.dout_x, ia.dout_y, ia.dout_local});
    end
    n_tests++;
    if ({ia.hol_x, ia.hol_y, ia.hol_local} !== 24'h0) begin
      n_fail++; $display("FAIL route_hol: got %h expected 0", {ia.hol_x, ia.hol_y, ia.hol_local});
    end
  endtask

  task automatic test_fill_wrap();
    ia.fail = 3'b100;
    for (int i = 0; i < 4; i++) begin
      ia.in_x_valid = 1; ia.in_x_data = hdr(2, 0, i);
      tick();
    end
    n_tests++;
    if (ia.in_x_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", ia.in_x_ready); end
    ia.in_x_data = hdr(2, 0, 'h99);
    tick();
    n_tests++;
    if (ia.in_x_ready !== 1'b0 || ia.pkt_x !== hdr(2, 0, 0)) begin
      n_fail++; $display("FAIL full_hold: ready=%b pkt=%h expected 0 %h", ia.in_x_ready, ia.pkt_x, hdr(2, 0, 0));
    end
    // Pop while full with valid still high: the offered packet must not slip in.
    ia.fail = 3'b000;
    tick();
    n_tests++;
    if (ia.in_x_ready !== 1'b1 || ia.pkt_x !== hdr(2, 0, 1)) begin
      n_fail++; $display("FAIL pop_one: ready=%b pkt=%h expected 1 %h", ia.in_x_ready, ia.pkt_x, hdr(2, 0, 1));
    end
    ia.fail = 3'b100;
    ia.in_x_data = hdr(2, 0, 4);
    tick();
    ia.in_x_valid = 0;
    n_tests++;
    if (ia.in_x_ready !== 1'b0) begin n_fail++; $display("FAIL refill_ready: got %b expected 0", ia.in_x_ready); end
    ia.fail = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (ia.pkt_x !== hdr(2, 0, k) || ia.dout_x !== 2'b01) begin
        n_fail++; $display("FAIL wrap_order_%0d: pkt=%h dout=%b expected %h 01", k, ia.pkt_x, ia.dout_x, hdr(2, 0, k));
      end
      tick();
    end
    n_tests++;
    if (ia.dout_x !== 2'b00 || ia.in_x_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_drained: dout=%b ready=%b expected 00 1", ia.dout_x, ia.in_x_ready);
    end
  endtask

  task automatic test_hol();
    ia.fail = 3'b100;
    ia.in_x_valid = 1; ia.in_x_data = hdr(1, 1, 'hA1);
    ia.in_y_valid = 1; ia.in_y_data = hdr(1, 1, 'hB2);
    tick();
    ia.in_x_valid = 0; ia.in_y_valid = 0;
    tick();
    n_tests++;
    if (ia.dout_y !== 2'b00 || ia.dout_x !== 2'b11) begin
      n_fail++; $display("FAIL hol_first_edge: dout_x=%b dout_y=%b expected 11 00", ia.dout_x, ia.dout_y);
    end
    tick();
    tick();
    n_tests++;
    if (ia.dout_x !== 2'b11 || ia.pkt_x !== hdr(1, 1, 'hA1)) begin
      n_fail++; $display("FAIL hol_head_kept: dout=%b pkt=%h expected 11 %h", ia.dout_x, ia.pkt_x, hdr(1, 1, 'hA1));
    end
    n_tests++;
    if (ia.hol_x !== 8'd3) begin n_fail++; $display("FAIL hol_count: got %0d expected 3", ia.hol_x); end
    ia.fail = 3'b000;
    tick();
    n_tests++;
    if (ia.dout_x !== 2'b00 || ia.hol_x !== 8'd0) begin
      n_fail++; $display("FAIL hol_release: dout=%b hol=%0d expected 00 0", ia.dout_x, ia.hol_x);
    end
  endtask

  task automatic test_empty_fail();
    ia.fail = 3'b111;
    repeat (3) tick();
    n_tests++;
    if ({ia.dout_x, ia.dout_y, ia.dout_local} !== 6'b0 || {ia.hol_x, ia.hol_y, ia.hol_local} !== 24'h0) begin
      n_fail++; $display("FAIL empty_fail: dout=%b hol=%h expected 0 0", {ia.dout_x, ia.dout_y, ia.dout_local},
                         {ia.hol_x, ia.hol_y, ia.hol_local});
    end
    n_tests++;
    if ({ia.in_x_ready, ia.in_y_ready, ia.in_l_ready} !== 3'b111) begin
      n_fail++; $display("FAIL empty_ready: got %b expected 111", {ia.in_x_ready, ia.in_y_ready, ia.in_l_ready});
    end
    ia.in_x_valid = 1; ia.in_x_data = hdr(0, 1, 'h5);
    tick();
    ia.in_x_valid = 0;
    ia.fail = 3'b000;
    n_tests++;
    if (ia.dout_x !== 2'b01) begin n_fail++; $display("FAIL empty_then_push: got %b expected 01", ia.dout_x); end
    tick();
    n_tests++;
    if (ia.dout_x !== 2'b00) begin n_fail++; $display("FAIL empty_count_zero: got %b expected 00", ia.dout_x); end
  endtask

  task automatic test_back_to_back();
    ia.fail = 3'b100;
    ia.in_x_valid = 1; ia.in_x_data = hdr(2, 2, 'hA);
    tick();
    ia.fail = 3'b000;
    ia.in_x_data = hdr(1, 0, 'hB);
    tick();
    ia.in_x_valid = 0;
    n_tests++;
    if (ia.pkt_x !== hdr(1, 0, 'hB) || ia.dout_x !== 2'b10) begin
      n_fail++; $display("FAIL b2b_new_head: pkt=%h dout=%b expected %h 10", ia.pkt_x, ia.dout_x, hdr(1, 0, 'hB));
    end
    ia.fail = 3'b100;
    tick();
    n_tests++;
    if (ia.pkt_x !== hdr(1, 0, 'hB) || ia.hol_x !== 8'd1) begin
      n_fail++; $display("FAIL b2b_hold: pkt=%h hol=%0d expected %h 1", ia.pkt_x, ia.hol_x, hdr(1, 0, 'hB));
    end
    ia.fail = 3'b000;
    tick();
    n_tests++;
    if (ia.dout_x !== 2'b00) begin n_fail++; $display("FAIL b2b_count_one: got %b expected 00", ia.dout_x); end
  endtask

  task automatic test_saturation();
    ib.fail = 3'b100;
    ib.in_x_valid = 1; ib.in_x_data = hdr(0, 0, 'h7);
    tick();
    ib.in_x_valid = 0;
    n_tests++;
    if (ib.dout_x !== 2'b11) begin n_fail++; $display("FAIL sat_route: got %b expected 11", ib.dout_x); end
    repeat (2) tick();
    n_tests++;
    if (ib.hol_x !== 2'd2) begin n_fail++; $display("FAIL sat_mid: got %0d expected 2", ib.hol_x); end
    repeat (3) tick();
    n_tests++;
    if (ib.hol_x !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", ib.hol_x); end
    ib.fail = 3'b000;
    tick();
    n_tests++;
    if (ib.hol_x !== 2'd0 || ib.dout_x !== 2'b00) begin
      n_fail++; $display("FAIL sat_release: hol=%0d dout=%b expected 0 00", ib.hol_x, ib.dout_x);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_fill_wrap();
    test_hol();
    test_empty_fail();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
